// File: rtl/apb_node_pipe.sv
// apb_node_pipe
// Registered APB interconnect node: one upstream completer port fanned out to
// NB_MASTER downstream requester ports. The node captures each upstream
// request and decodes it against a programmable inclusive address map. It then
// replays the request downstream as a SETUP/ACCESS pair and returns a
// registered one-cycle response.
//
// An access that matches no port is answered by an internal default slave
// (pslverr=1, prdata=0) and pulses decerr_o. A selected slave that holds
// pready low for TIMEOUT_CYCLES ACCESS cycles is abandoned with pslverr=1 and
// pulses timeout_o.
//
// Upstream handshake: the node takes a request in IDLE whenever psel_i=1;
// penable_i is ignored. The requester must drop psel_i once it sees pready_o.
// pready_o is high for exactly one cycle per accepted request, and prdata_o and
// pslverr_o are valid only in that cycle. Downstream: psel_o is one-hot, and
// penable_o follows APB SETUP->ACCESS. The selected slave completes the transfer
// by raising pready_i[sel] in ACCESS.
module apb_node_pipe #(
    parameter int unsigned NB_MASTER      = 8,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    // upstream completer port
    input  logic                                          psel_i,
    input  logic                                          penable_i,
    input  logic                                          pwrite_i,
    input  logic [APB_ADDR_WIDTH-1:0]                     paddr_i,
    input  logic [APB_DATA_WIDTH-1:0]                     pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]                     prdata_o,
    output logic                                          pready_o,
    output logic                                          pslverr_o,
    // downstream requester ports
    output logic [NB_MASTER-1:0]                          psel_o,
    output logic                                          penable_o,
    output logic                                          pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]                     paddr_o,
    output logic [APB_DATA_WIDTH-1:0]                     pwdata_o,
    input  logic [NB_MASTER-1:0][APB_DATA_WIDTH-1:0]      prdata_i,
    input  logic [NB_MASTER-1:0]                          pready_i,
    input  logic [NB_MASTER-1:0]                          pslverr_i,
    // address map, inclusive per port
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      start_addr_i,
    input  logic [NB_MASTER-1:0][APB_ADDR_WIDTH-1:0]      end_addr_i,
    // status pulses
    output logic                                          decerr_o,
    output logic                                          timeout_o
);

    // Port index width (at least one bit so NB_MASTER=1 still elaborates).
    localparam int unsigned SW = (NB_MASTER > 1) ? $clog2(NB_MASTER) : 1;
    // Watchdog width holds 0..TIMEOUT_CYCLES; one bit when the watchdog is off.
    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Count value seen in the last ACCESS cycle before the watchdog fires.
    localparam logic [CW-1:0] CNT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e                    state_q, state_d;

    // request capture
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic [SW-1:0]             sel_q, sel_d;

    // watchdog
    logic [CW-1:0]             cnt_q, cnt_d;

    // registered response and status
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic                      decerr_q, decerr_d;
    logic                      timeout_q, timeout_d;

    // address decode result for the live upstream address
    logic                      hit;
    logic [SW-1:0]             hit_idx;

    // penable_i carries no information for this node; it is accepted on the
    // port list for APB completeness only.
    logic                      unused_penable;
    assign unused_penable = penable_i;

    // Decode: lowest-indexed port whose inclusive range covers paddr_i wins.
    // Scanning downwards lets each lower match overwrite any higher one.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NB_MASTER) - 1; i >= 0; i--) begin
            if ((paddr_i >= start_addr_i[i]) && (paddr_i <= end_addr_i[i])) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    // Next-state and capture logic for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        prdata_d  = '0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        decerr_d  = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (psel_i) begin
                    addr_d  = paddr_i;
                    wdata_d = pwdata_i;
                    write_d = pwrite_i;
                    if (hit) begin
                        sel_d   = hit_idx;
                        state_d = S_SETUP;
                    end else begin
                        // Default slave answers directly; no port is touched.
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        decerr_d  = 1'b1;
                    end
                end
            end

            S_SETUP: begin
                state_d = S_ACCESS;
                cnt_d   = '0;
            end

            S_ACCESS: begin
                if (pready_i[sel_q]) begin
                    // A ready slave always wins over a watchdog expiring now.
                    state_d   = S_RESP;
                    pready_d  = 1'b1;
                    prdata_d  = prdata_i[sel_q];
                    pslverr_d = pslverr_i[sel_q];
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                        state_d   = S_RESP;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        timeout_d = 1'b1;
                    end
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, capture and response registers; reset drops any transfer in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            sel_q     <= '0;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            decerr_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            decerr_q  <= decerr_d;
            timeout_q <= timeout_d;
        end
    end

    // Downstream select: one-hot on the captured port during SETUP and ACCESS.
    always_comb begin
        psel_o = '0;
        if ((state_q == S_SETUP) || (state_q == S_ACCESS)) begin
            psel_o[sel_q] = 1'b1;
        end
    end

    // Shared downstream controls come straight from the capture registers, so
    // they stay stable from SETUP through the end of ACCESS.
    assign penable_o = (state_q == S_ACCESS);
    assign pwrite_o  = write_q;
    assign paddr_o   = addr_q;
    assign pwdata_o  = wdata_q;

    // Upstream response and status pulses are all high only in the RESP cycle.
    assign prdata_o  = prdata_q;
    assign pready_o  = pready_q;
    assign pslverr_o = pslverr_q;
    assign decerr_o  = decerr_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_apb_node_pipe.sv
// Bench for apb_node_pipe: the driver issues upstream requests and pushes
// expected responses, a monitor pops and compares on pready_o, and a slave
// model answers on the downstream ports with programmable wait states.
module tb_apb_node_pipe;

  localparam int NB  = 8;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        dec;
    logic        tmo;
    int          lat;
    int          port;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          issue;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic                   psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [AW-1:0]          paddr_i = '0;
  logic [DW-1:0]          pwdata_i = '0;
  logic [DW-1:0]          prdata_o;
  logic                   pready_o, pslverr_o;
  logic [NB-1:0]          psel_o;
  logic                   penable_o, pwrite_o;
  logic [AW-1:0]          paddr_o;
  logic [DW-1:0]          pwdata_o;
  logic [NB-1:0][DW-1:0]  prdata_i;
  logic [NB-1:0]          pready_i, pslverr_i;
  logic [NB-1:0][AW-1:0]  map_st, map_en;
  logic                   decerr_o, timeout_o;

  apb_node_pipe #(
    .NB_MASTER(NB), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .start_addr_i(map_st), .end_addr_i(map_en),
    .decerr_o(decerr_o), .timeout_o(timeout_o)
  );

  // scoreboard state
  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  int   sel_cnt = 0;

  // slave model configuration for the transfer in flight
  int          sl_waits = 0;
  logic [31:0] sl_rdata = '0;
  logic        sl_err = 1'b0;
  int          acc_cnt = 0;
  logic [NB-1:0]         junk_rdy = '0, junk_err = '0;
  logic [NB-1:0][DW-1:0] junk_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: counts ACCESS cycles; unselected ports carry random noise.
  always @(posedge clk) begin
    if (!rst_ni || !penable_o) acc_cnt <= 0;
    else acc_cnt <= acc_cnt + 1;
    junk_rdy <= NB'($urandom);
    junk_err <= NB'($urandom);
    for (int i = 0; i < NB; i++) junk_data[i] <= $urandom;
  end

  always_comb begin
    pready_i  = junk_rdy;
    pslverr_i = junk_err;
    prdata_i  = junk_data;
    for (int i = 0; i < NB; i++) begin
      if (psel_o[i]) begin
        pready_i[i]  = penable_o && (acc_cnt == sl_waits);
        pslverr_i[i] = sl_err;
        prdata_i[i]  = sl_rdata;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // reference model: lowest port whose inclusive range covers the address
  function automatic int model_decode(input logic [31:0] a);
    for (int i = 0; i < NB; i++)
      if (a >= map_st[i] && a <= map_en[i]) return i;
    return -1;
  endfunction

  task automatic init_map();
    for (int i = 0; i < NB; i++) begin
      map_st[i] = 32'h4000_0000;  // empty range (start > end)
      map_en[i] = 32'h3FFF_FFFF;
    end
    map_st[0] = 32'h1A10_0000; map_en[0] = 32'h1A10_0FFF;
    map_st[1] = 32'h1A10_1000; map_en[1] = 32'h1A10_1FFF;
    map_st[2] = 32'h1A10_1000; map_en[2] = 32'h1A10_2FFF;
    map_st[3] = 32'h1A10_3000; map_en[3] = 32'h1A10_3FFF;
    map_st[4] = 32'h1A10_4000; map_en[4] = 32'h1A10_7FFF;
    map_st[5] = 32'h1A10_8000; map_en[5] = 32'h1A10_8FFF;
    map_st[6] = 32'h0000_0000; map_en[6] = 32'h0000_00FF;
  endtask

  task automatic scramble_map();
    int i;
    logic [31:0] base;
    i = $urandom_range(0, NB - 1);
    base = 32'h1A10_0000 + ($urandom_range(0, 9) << 12);
    map_st[i] = base;
    map_en[i] = base + ($urandom_range(0, 3) << 12) + 32'hFFF;
    if ($urandom_range(0, 4) == 0) begin
      map_st[i] = 32'hFFFF_FFFF;
      map_en[i] = 32'h0;
    end
  endtask

  // Driver: present a request for one cycle, then scramble upstream inputs.
  task automatic issue_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                            input int waits, input logic [31:0] rd, input logic er,
                            input logic scramble);
    exp_t e;
    e.port  = model_decode(a);
    e.addr  = a;
    e.wdata = wd;
    e.wr    = wr;
    e.issue = cyc;
    e.dec   = 1'b0;
    e.tmo   = 1'b0;
    if (e.port < 0) begin
      e.rdata = '0; e.err = 1'b1; e.dec = 1'b1; e.lat = 1;
    end else if (waits < TMO) begin
      e.rdata = rd; e.err = er; e.lat = 3 + waits;
    end else begin
      e.rdata = '0; e.err = 1'b1; e.tmo = 1'b1; e.lat = TMO + 2;
    end
    sl_waits = waits; sl_rdata = rd; sl_err = er;
    psel_i = 1'b1; penable_i = 1'($urandom_range(0, 1));
    paddr_i = a; pwdata_i = wd; pwrite_i = wr;
    exp_q.push_back(e);
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'($urandom_range(0, 1));
    paddr_i = $urandom; pwdata_i = $urandom; pwrite_i = 1'($urandom_range(0, 1));
    if (scramble) scramble_map();
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL wait_response: no pready_o within %0d cycles, %0d pending", n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_xfer(input logic [31:0] a, input logic [31:0] wd, input logic wr,
                         input int waits, input logic [31:0] rd, input logic er,
                         input logic scramble);
    issue_xfer(a, wd, wr, waits, rd, er, scramble);
    wait_done();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_psel"}, 32'(psel_o), 0);
    chk({tag, "_penable"}, 32'(penable_o), 0);
    chk({tag, "_pwrite"}, 32'(pwrite_o), 0);
    chk({tag, "_paddr"}, paddr_o, 0);
    chk({tag, "_pwdata"}, pwdata_o, 0);
    chk({tag, "_pready"}, 32'(pready_o), 0);
    chk({tag, "_pslverr"}, 32'(pslverr_o), 0);
    chk({tag, "_prdata"}, prdata_o, 0);
    chk({tag, "_decerr"}, 32'(decerr_o), 0);
    chk({tag, "_timeout"}, 32'(timeout_o), 0);
  endtask

  // Monitor: downstream protocol checks and response scoreboard.
  initial begin
    exp_t e;
    logic [NB-1:0] es;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (psel_o != '0) begin
          if (exp_q.size() == 0) begin
            chk("psel_unexpected", 32'(psel_o), 0);
          end else begin
            e = exp_q[0];
            es = (e.port >= 0) ? (NB'(1) << e.port) : '0;
            chk("psel_onehot", 32'(psel_o), 32'(es));
            chk("penable_phase", 32'(penable_o), 32'(sel_cnt > 0));
            chk("paddr_out", paddr_o, e.addr);
            chk("pwdata_out", pwdata_o, e.wdata);
            chk("pwrite_out", 32'(pwrite_o), 32'(e.wr));
            chk("pready_during_sel", 32'(pready_o), 0);
          end
        end
        if (pready_o) begin
          if (exp_q.size() == 0) begin
            chk("pready_unexpected", 32'(pready_o), 0);
          end else begin
            e = exp_q.pop_front();
            chk("prdata", prdata_o, e.rdata);
            chk("pslverr", 32'(pslverr_o), 32'(e.err));
            chk("decerr", 32'(decerr_o), 32'(e.dec));
            chk("timeout", 32'(timeout_o), 32'(e.tmo));
            chk("latency", 32'(cyc - e.issue), 32'(e.lat));
            chk("psel_in_resp", 32'(psel_o), 0);
          end
        end else begin
          chk("prdata_idle", prdata_o, 0);
          chk("pslverr_idle", 32'(pslverr_o), 0);
          chk("decerr_idle", 32'(decerr_o), 0);
          chk("timeout_idle", 32'(timeout_o), 0);
        end
      end
      if (psel_o != '0) sel_cnt++;
      else sel_cnt = 0;
    end
  end

  // Global time bound.
  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "global timeout");
  end

  // Stimulus.
  initial begin
    logic [31:0] a;
    init_map();
    rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;
    chk_outputs_zero("post_reset");
    mon_en = 1'b1;

    // zero-wait write to port 3
    do_xfer(32'h1A10_3004, 32'hCAFE_F00D, 1'b1, 0, 32'h0BAD_0BAD, 1'b0, 1'b0);
    // read from port 0 with two wait states
    do_xfer(32'h1A10_0010, 32'h0, 1'b0, 2, 32'h1234_5678, 1'b0, 1'b0);
    // unmapped access
    do_xfer(32'h2000_0000, 32'h5555_AAAA, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    // hung slave on port 3, then a normal read of port 0
    do_xfer(32'h1A10_3008, 32'h1111_2222, 1'b1, 100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    do_xfer(32'h1A10_0020, 32'h0, 1'b0, 0, 32'hA5A5_5A5A, 1'b0, 1'b0);
    // overlap of ports 1 and 2 resolves to port 1
    do_xfer(32'h1A10_1000, 32'h3333_4444, 1'b0, 1, 32'h7777_8888, 1'b0, 1'b0);
    // ready in the same cycle the watchdog would expire
    do_xfer(32'h1A10_4000, 32'h0, 1'b0, TMO - 1, 32'h0F0F_F0F0, 1'b1, 1'b0);
    // range edges
    do_xfer(32'h1A10_0FFF, 32'h0, 1'b0, 0, 32'h1357_9BDF, 1'b0, 1'b0);
    do_xfer(32'h1A10_2FFF, 32'h0, 1'b0, 0, 32'h2468_ACE0, 1'b1, 1'b0);
    do_xfer(32'h1A10_9000, 32'h0, 1'b0, 0, 32'h0, 1'b0, 1'b0);
    do_xfer(32'h0000_0000, 32'h9999_0000, 1'b1, 0, 32'hC0DE_C0DE, 1'b0, 1'b0);

    // reset asserted during ACCESS drops the transfer
    issue_xfer(32'h1A10_3010, 32'hABCD_EF01, 1'b1, 100, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("pre_reset_penable", 32'(penable_o), 1);
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_outputs_zero("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("held_reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    do_xfer(32'h1A10_3014, 32'h0102_0304, 1'b1, 0, 32'h0, 1'b0, 1'b0);

    // randomized traffic with occasional map changes during transfers
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'h1A10_0000 + $urandom_range(0, 32'hAFFF);
      do_xfer(a, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom,
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_node_pipe.md
# apb_node_pipe

Registered APB 3-level interconnect node: one upstream APB completer port fanned out to NB_MASTER downstream APB requester ports, with a programmable address map, registered decode and response, a decode-error default slave and a per-transfer pready watchdog. It sits between the SoC APB bridge and the peripheral subsystem. It generalises the combinational APB node with pipelining, error responses for unmapped addresses, hung-slave timeout and status pulses.

## Interface
- NB_MASTER, 8, number of downstream ports (1..32)
- APB_ADDR_WIDTH, 32, address width
- APB_DATA_WIDTH, 32, data width
- TIMEOUT_CYCLES, 256, max ACCESS cycles waiting for pready; 0 disables watchdog
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset: asynchronous, active-low
- psel_i, penable_i, pwrite_i  in  1 each  upstream APB controls
- paddr_i  in  APB_ADDR_WIDTH  upstream address
- pwdata_i  in  APB_DATA_WIDTH  upstream write data
- prdata_o  out  APB_DATA_WIDTH  upstream read data (registered)
- pready_o, pslverr_o  out  1 each  upstream response (registered)
- psel_o  out  NB_MASTER  one-hot downstream select
- penable_o, pwrite_o  out  1 each  shared downstream controls
- paddr_o  out  APB_ADDR_WIDTH  shared downstream address
- pwdata_o  out  APB_DATA_WIDTH  shared downstream write data
- prdata_i  in  NB_MASTER x APB_DATA_WIDTH  downstream read data, packed [NB_MASTER-1:0][W-1:0]
- pready_i, pslverr_i  in  NB_MASTER  downstream responses
- start_addr_i, end_addr_i  in  NB_MASTER x APB_ADDR_WIDTH  inclusive range per port
- decerr_o  out  1  one-cycle pulse on unmapped access
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: when psel_i=1 (penable_i ignored), capture paddr_i, pwdata_i, pwrite_i into registers; decode port = lowest index i with start_addr_i[i] <= addr <= end_addr_i[i] (unsigned). Hit -> SETUP with sel register = i. Miss -> RESP with pslverr=1, prdata=0, decerr_o=1 that cycle.
- SETUP: psel_o[sel]=1, penable_o=0; paddr_o/pwdata_o/pwrite_o from capture registers. Next state ACCESS unconditionally; watchdog count cleared.
- ACCESS: psel_o[sel]=1, penable_o=1. If pready_i[sel]=1: capture prdata_i[sel] and pslverr_i[sel], go RESP. Else count++; if TIMEOUT_CYCLES!=0 and count==TIMEOUT_CYCLES-1: go RESP with pslverr=1, prdata=0, timeout_o=1 that cycle.
- pready of non-selected ports ignored; ready wins over timeout in the same cycle.
- RESP: pready_o=1 for exactly one cycle with captured prdata_o/pslverr_o; psel_o=0, penable_o=0; next state IDLE.
- pready_o=0 in all states except RESP; prdata_o/pslverr_o are 0 outside RESP.
- Upstream inputs changing after capture have no effect on the current transfer.
- Watchdog counter width $clog2(TIMEOUT_CYCLES+1), saturates, never wraps.
- Address map may change at any time; it is sampled only in IDLE.
- Reset (any state): state=IDLE, all outputs 0, capture registers and counter 0; an in-flight transfer is dropped without a response.

## Timing
- Cycle 0: IDLE samples psel_i. Cycle 1: SETUP. Cycle 2: ACCESS (earliest pready_i). Cycle 3: RESP, pready_o=1.
- Zero-wait-state latency: 3 cycles from psel_i to pready_o; each slave wait state adds 1.
- Decode error: pready_o in cycle 1 (1-cycle latency).
- Timeout: pready_o asserted TIMEOUT_CYCLES+2 cycles after capture.
- Back-to-back: a new psel_i is accepted in the cycle after RESP; throughput 1 transfer per 4 cycles at zero wait.
- Downstream signals held stable from SETUP through ACCESS end, per APB.

## Test plan
- Map port 0 = 0x1A100000..0x1A100FFF, port 3 = 0x1A103000..0x1A103FFF; write 0xCAFEF00D to 0x1A103004 -> psel_o=0b1000 cycles 1-2, penable_o=1 cycle 2, pwdata_o=0xCAFEF00D, pready_o=1 cycle 3, pslverr_o=0.
- Read 0x1A100010, port 0 inserts 2 wait states returning 0x12345678 -> pready_o in cycle 5, prdata_o=0x12345678.
- Access 0x20000000 (unmapped) -> no psel_o bit set, pready_o=1 and pslverr_o=1 in cycle 1, decerr_o pulse, prdata_o=0.
- TIMEOUT_CYCLES=4, port 3 never ready -> ACCESS 4 cycles, timeout_o pulse, pready_o=1 with pslverr_o=1, psel_o drops; next transfer to port 0 completes normally.
- Overlapping ranges ports 1 and 2 both cover 0x1A101000 -> only psel_o[1] asserted.
- Assert rst_ni=0 during ACCESS -> all outputs 0 immediately, FSM IDLE; after release, a fresh write completes in 3 cycles.
